// File: rtl/seven_seg_scan_mux.sv
// seven_seg_scan_mux: time-multiplexes three 14-bit two-digit segment buses
// (hours, minutes, seconds) onto a 6-digit common-anode 7-segment display.
// Captures all inputs once per frame, inserts a ghosting guard at the start
// of every digit slot and blinks the field currently under edit.
// Optional feature macro: SCAN_DP_COLON_EN drives dp low on digits 2 and 4
// (colon separators HH.MM.SS); otherwise dp is tied high.
module seven_seg_scan_mux #(
  parameter int SCAN_DIV  = 50000,
  parameter int GUARD     = 16,
  parameter int BLINK_DIV = 12500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] hour1,
  input  logic [13:0] minute1,
  input  logic [13:0] second1,
  input  logic [1:0]  edit_sel,
  output logic [5:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SC_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SC_GUARD = SW'(GUARD);
  localparam logic [BW-1:0] BC_LAST  = BW'(BLINK_DIV - 1);

  // Frame snapshot: digit 0 = seconds ones ... digit 5 = hours tens.
  typedef struct packed {
    logic [5:0][6:0] dig;
    logic [1:0]      es;
  } snap_t;

  logic [SW-1:0] sc;
  logic [2:0]    idx;
  logic [BW-1:0] bc;
  logic          vis;
  logic [1:0]    es_q;
  snap_t         snap;

  logic          in_guard;
  logic [6:0]    dig_seg;
  logic [1:0]    dig_fld;
  logic          fld_hit;
  logic [5:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  // Slot counter and digit index; a full frame is 6 slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      sc  <= '0;
      idx <= '0;
    end else if (sc == SC_LAST) begin
      sc  <= '0;
      idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      sc  <= sc + 1'b1;
    end
  end

  // Capture all inputs at the start of each frame so a frame is coherent.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap.dig <= '1;
      snap.es  <= 2'd0;
    end else if (sc == '0 && idx == 3'd0) begin
      snap.dig <= {hour1, minute1, second1};
      snap.es  <= edit_sel;
    end
  end

  // Blink timebase; a change of the live edit field restarts in the visible phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      bc   <= '0;
      vis  <= 1'b1;
      es_q <= 2'd0;
    end else begin
      es_q <= edit_sel;
      if (edit_sel != es_q) begin
        bc  <= '0;
        vis <= 1'b1;
      end else if (bc == BC_LAST) begin
        bc  <= '0;
        vis <= ~vis;
      end else begin
        bc  <= bc + 1'b1;
      end
    end
  end

  // Select the current digit's code and the field it belongs to.
  always_comb begin
    dig_seg = 7'h7F;
    dig_fld = 2'd0;
    case (idx)
      3'd0: begin dig_seg = snap.dig[0]; dig_fld = 2'd1; end
      3'd1: begin dig_seg = snap.dig[1]; dig_fld = 2'd1; end
      3'd2: begin dig_seg = snap.dig[2]; dig_fld = 2'd2; end
      3'd3: begin dig_seg = snap.dig[3]; dig_fld = 2'd2; end
      3'd4: begin dig_seg = snap.dig[4]; dig_fld = 2'd3; end
      3'd5: begin dig_seg = snap.dig[5]; dig_fld = 2'd3; end
      default: begin dig_seg = 7'h7F; dig_fld = 2'd0; end
    endcase
  end

  // Next output values: guard blanks anodes, blink blanks segments only.
  always_comb begin
    in_guard = (sc < SC_GUARD);
    fld_hit  = (snap.es != 2'd0) && (dig_fld == snap.es);
    an_nxt   = in_guard ? 6'h3F : ~(6'b1 << idx);
    seg_nxt  = (!vis && fld_hit) ? 7'h7F : dig_seg;
`ifdef SCAN_DP_COLON_EN
    dp_nxt   = !(!in_guard && (idx == 3'd2 || idx == 3'd4));
`else
    dp_nxt   = 1'b1;
`endif
  end

  // Registered pin drivers.
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 6'h3F;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: doc/seven_seg_scan_mux.md
# seven_seg_scan_mux

Downstream display stage of the clock: consumes the three 14-bit two-digit segment buses produced by the mode/counter stage (hours, minutes, seconds) and time-multiplexes them onto a 6-digit common-anode 7-segment display. Blinks the field currently being edited. Includes inter-digit ghosting guard and frame-coherent input capture. Registered outputs drive board pins directly.

## Interface
- SCAN_DIV, 50000: clock cycles per digit slot; legal range ≥ 2.
- GUARD, 16: cycles at the start of each slot with all anodes off; legal range 0 ≤ GUARD < SCAN_DIV.
- BLINK_DIV, 12500000: clock cycles per blink half-period.
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- hour1  in  14  [13:7] tens-digit segments, [6:0] ones-digit segments; active-low, bit order gfedcba.
- minute1  in  14  same format as hour1.
- second1  in  14  same format as hour1.
- edit_sel  in  2  field under edit, using the mode-stage count encoding: 0 none, 1 seconds, 2 minutes, 3 hours.
- an  out  6  digit enables, active-low, one-hot or all-ones.
  - Digit 0 = seconds ones, 1 = seconds tens, 2 = minutes ones, 3 = minutes tens, 4 = hours ones, 5 = hours tens.
- seg  out  7  segments, active-low, gfedcba.
- dp  out  1  decimal point, active-low.

## Operation
- **State:**
  - slot counter `sc`, 0..SCAN_DIV-1.
  - digit index `idx`, 0..5.
  - 42-bit snapshot plus 2-bit snapshot of edit_sel.
  - blink counter `bc`, 0..BLINK_DIV-1, and blink phase `vis`.
- **Scan:**
  - `sc` increments each cycle. At SCAN_DIV-1 it wraps to 0 and `idx` advances.
  - `idx` wraps 5 → 0.
- **Frame capture:**
  - On every cycle where `sc==0` and `idx==0`, hour1/minute1/second1/edit_sel are captured into the snapshot.
  - This includes the first cycle after reset release.
  - Input changes mid-frame never appear until the next frame.
- **Guard:** while `sc < GUARD`, `an` is 6'h3F. Otherwise `an = ~(6'b1 << idx)`.
- **Segment select:** `seg` is the snapshot 7-bit field for `idx`.
- **Blink:**
  - `bc` free-runs. At BLINK_DIV-1 it wraps and `vis` toggles.
  - When `vis==0` and `idx` belongs to the snapshot-selected field (1 → digits 0,1; 2 → 2,3; 3 → 4,5), `seg` is forced to 7'h7F.
  - In that case `an` is still driven normally.
  - Snapshot edit_sel = 0: no digit ever blanks.
- **Blink restart:**
  - When the live edit_sel differs from its value in the previous cycle, `bc` clears to 0 and `vis` is set to 1 on that edge.
  - Result: a newly selected field is immediately visible for a full half-period.
- **dp:** see Configuration.
- **Reset:**
  - `sc`=0, `idx`=0, `bc`=0, `vis`=1.
  - Snapshot = all ones, snapshot edit_sel = 0.
  - Outputs: `an`=6'h3F, `seg`=7'h7F, `dp`=1.
  - Reset mid-slot or mid-frame aborts the scan and restarts at digit 0.

## Timing
- All outputs are registered. Output values are a function of the previous cycle's `sc`/`idx`/`vis`/snapshot (1-cycle latency).
- Digit slot: exactly SCAN_DIV cycles.
  - `an` all-high for GUARD cycles, then one digit low for SCAN_DIV-GUARD cycles.
  - Frame = 6·SCAN_DIV cycles.
- Input-to-display latency: up to 6·SCAN_DIV+1 cycles (next frame capture + 1 register).
- First output after reset release:
  - Cycle 1: snapshot captured.
  - `an` for digit 0 asserts on the cycle after `sc` reaches GUARD.
- Blink period: 2·BLINK_DIV cycles. Restart on edit_sel change takes effect the same edge; blanking visible on outputs 1 cycle later.
- Simultaneous blink wrap and edit_sel change: restart wins (`vis`=1, `bc`=0).
- Simultaneous rst with anything: rst wins.

## Configuration
- SCAN_DP_COLON_EN defined:
  - `dp`=0 while digits 2 or 4 are enabled (colon separators HH.MM.SS).
  - Not blanked by blink.
  - 1 during guard and on all other digits.
- SCAN_DP_COLON_EN undefined: `dp` tied to constant 1. Port remains present.

## Test plan
Parameters for all tests: SCAN_DIV=8, GUARD=2, BLINK_DIV=64.

1. **Reset:** rst high 3 cycles mid-scan → `an`=6'h3F, `seg`=7'h7F, `dp`=1 on the cycle after the first rst edge. After release, first enabled `an`=6'h3E.
2. **Scan order:** hour1={7'h79,7'h24}, minute1={7'h30,7'h19}, second1={7'h12,7'h02}, edit_sel=0.
   - Required `an` sequence: 3E,3D,3B,37,2F,1F.
   - Required `seg` sequence: 02,12,19,30,24,79.
   - Each digit enabled 6 cycles, preceded by 2 all-high cycles.
   - Pattern repeats every 48 cycles.
3. **Frame coherence:** change second1 to {7'h40,7'h40} while `idx`=3 → digits 0/1 keep the old codes for the rest of the frame. New codes (40,40) appear from the next frame's digit 0.
4. **Blink:** edit_sel=2 held →
   - Digits 2,3 show `seg`=7'h7F for 64 cycles out of every 128.
   - Digits 0,1,4,5 never blank.
   - `an` sequence unchanged.
5. **Blink restart:** switch edit_sel 2→3 while `vis`=0 → `vis`=1 next cycle. Hours are visible for ≥64 cycles before first blanking; minutes no longer blank.
6. **Macro:** with SCAN_DP_COLON_EN, `dp`=0 exactly while `an`=3B or 2F, including during blanked phases. Without the macro, `dp`=1 throughout test 2.
